// File: rtl/division_sequential.sv
// division_sequential: restoring shift-subtract divider, signed or unsigned, one quotient bit per cycle.
// Ports: clock/clear (async active-high reset); start, signed_mode, a, b sampled in IDLE;
//        busy (CALC/SIGN), done (one-cycle DONE pulse), z = {remainder, quotient},
//        div_by_zero and overflow flags describing the current z.
module division_sequential #(
    parameter int WIDTH          = 32,
    parameter bit SIGNED_DEFAULT = 1'b1
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   z,
    output logic                 div_by_zero,
    output logic                 overflow
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;
    state_t             state_q, state_d;
    logic               mode_q, mode_d, a_neg_q, a_neg_d, b_neg_q, b_neg_d;
    logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] z_q, z_d;
    logic               dbz_q, dbz_d, ovf_q, ovf_d;
    logic [WIDTH-1:0]   a_mag, b_mag, q_fix, r_fix;
    logic [WIDTH:0]     shifted, diff;
    logic               fits;
    always_comb begin
        a_mag   = (signed_mode && a[WIDTH-1]) ? -a : a;
        b_mag   = (signed_mode && b[WIDTH-1]) ? -b : b;
        // remainder stays below the divisor, so the WIDTH+1-bit shifted value never overflows
        shifted = {rem_q, quo_q[WIDTH-1]};
        fits    = shifted >= {1'b0, dvs_q};
        diff    = shifted - {1'b0, dvs_q};
        q_fix   = (mode_q && (a_neg_q ^ b_neg_q)) ? -quo_q : quo_q;
        r_fix   = (mode_q && a_neg_q) ? -rem_q : rem_q;
        state_d = state_q;
        mode_d  = mode_q;
        a_neg_d = a_neg_q;
        b_neg_d = b_neg_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        z_d     = z_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (start) begin
                mode_d  = signed_mode;
                a_neg_d = signed_mode & a[WIDTH-1];
                b_neg_d = signed_mode & b[WIDTH-1];
                quo_d   = a_mag;
                rem_d   = '0;
                dvs_d   = b_mag;
                cnt_d   = '0;
                if (b == '0) begin
                    state_d = DONE;
                    z_d     = {a, {WIDTH{1'b1}}};
                    dbz_d   = 1'b1;
                    ovf_d   = 1'b0;
                end else begin
                    state_d = CALC;
                end
            end
            CALC: begin
                rem_d   = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                quo_d   = {quo_q[WIDTH-2:0], fits};
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(WIDTH - 1)) ? SIGN : CALC;
            end
            SIGN: begin
                z_d     = {r_fix, q_fix};
                dbz_d   = 1'b0;
                // most-negative / -1: both magnitudes give quotient 2^(WIDTH-1), which wraps
                ovf_d   = mode_q & a_neg_q & b_neg_q & (dvs_q == WIDTH'(1))
                        & (quo_q == {1'b1, {(WIDTH-1){1'b0}}});
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
            mode_q  <= SIGNED_DEFAULT;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            z_q     <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end
    assign busy        = (state_q == CALC) || (state_q == SIGN);
    assign done        = state_q == DONE;
    assign z           = z_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;
endmodule

// File: tb/tb_division_sequential.sv
// tb_division_sequential: randomized and directed checks of division_sequential against an arithmetic model.
module tb_division_sequential;
    logic        clock = 1'b0, clear = 1'b1, start = 1'b0, signed_mode = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, div_by_zero, overflow;
    logic [63:0] z;
    int          n_vec = 0, n_err = 0;
    logic        both_high = 1'b0;

    division_sequential #(.WIDTH(32), .SIGNED_DEFAULT(1'b1)) dut (
        .clock(clock), .clear(clear), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy), .done(done), .z(z),
        .div_by_zero(div_by_zero), .overflow(overflow)
    );

    always #5 clock = ~clock;
    always @(negedge clock) if (busy && done) both_high = 1'b1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // returns {overflow, div_by_zero, remainder, quotient}
    function automatic logic [65:0] model(input logic [31:0] ma, input logic [31:0] mb, input logic ms);
        longint sa, sb, q, r;
        logic   ov;
        if (mb == 32'd0) return {1'b0, 1'b1, ma, 32'hFFFF_FFFF};
        sa = ms ? longint'($signed(ma)) : longint'({32'd0, ma});
        sb = ms ? longint'($signed(mb)) : longint'({32'd0, mb});
        q  = sa / sb;
        r  = sa % sb;
        ov = ms && ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF;
        return {ov, 1'b0, r[31:0], q[31:0]};
    endfunction

    // pulse_at > 0: a stray start with other operands during that CALC edge count
    task automatic run(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                       input logic ts, input int pulse_at);
        logic [65:0] exp;
        int          edges;
        exp = model(ta, tb_v, ts);
        @(negedge clock);
        a = ta; b = tb_v; signed_mode = ts; start = 1'b1;
        @(posedge clock);
        edges = 1;
        #1 start = 1'b0;
        a = $urandom; b = $urandom; signed_mode = $urandom_range(0, 1);
        forever begin
            @(negedge clock);
            if (done) break;
            if (edges > 100) begin
                chk({tag, " timeout"}, 64'(edges), 64'(tb_v == 0 ? 1 : 34));
                return;
            end
            if (pulse_at > 0 && edges == pulse_at) begin
                start = 1'b1; a = 32'd77; b = 32'd5; signed_mode = 1'b0;
            end
            @(posedge clock);
            edges++;
            #1 start = 1'b0;
        end
        chk({tag, " latency"}, 64'(edges), 64'(tb_v == 0 ? 1 : 34));
        chk({tag, " z"}, z, exp[63:0]);
        chk({tag, " flags"}, {62'd0, overflow, div_by_zero}, {62'd0, exp[65:64]});
        @(negedge clock);
        chk({tag, " done pulse"}, {63'd0, done}, 64'd0);
        chk({tag, " z hold"}, z, exp[63:0]);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        chk("reset z", z, 64'd0);
        chk("reset ctl", {60'd0, busy, done, div_by_zero, overflow}, 64'd0);
        clear = 1'b0;
        run("s100/7", 32'd100, 32'd7, 1'b1, 0);
        run("s-100/7", 32'hFFFF_FF9C, 32'd7, 1'b1, 0);
        run("s100/-7", 32'd100, 32'hFFFF_FFF9, 1'b1, 0);
        run("uFFFF/2", 32'hFFFF_FFFF, 32'd2, 1'b0, 0);
        run("sFFFF/2", 32'hFFFF_FFFF, 32'd2, 1'b1, 0);
        run("div0", 32'h1234, 32'd0, 1'b1, 0);
        run("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
        run("u8000/1", 32'h8000_0000, 32'd1, 1'b0, 0);
        run("uA/big", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 0);
        run("stray start", 32'd1000, 32'd33, 1'b1, 10);
        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 20));
                2: rb = rb >> $urandom_range(1, 30);
                3: ra = 32'h8000_0000;
                default: ;
            endcase
            run($sformatf("rnd%0d", i), ra, rb, 1'($urandom_range(0, 1)), 0);
        end
        @(negedge clock);
        a = 32'd100; b = 32'd7; signed_mode = 1'b1; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (14) @(posedge clock);
        #2 clear = 1'b1;
        #1;
        chk("clear z", z, 64'd0);
        chk("clear ctl", {60'd0, busy, done, div_by_zero, overflow}, 64'd0);
        @(negedge clock);
        clear = 1'b0;
        run("after clear 9/3", 32'd9, 32'd3, 1'b1, 0);
        chk("busy&done", {63'd0, both_high}, 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/division_sequential.md
DIVISION_SEQUENTIAL -- requirements
Module: division_sequential

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand width in bits (legal 4..64).
REQ-002 SHALL provide parameter SIGNED_DEFAULT, default 1, the signed_mode value forced by reset on the internal mode register.
REQ-003 SHALL have port clock  input  1  sole clock; all state changes on the rising edge.
REQ-004 SHALL have port clear  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  request a division; sampled on the rising edge of clock.
REQ-006 SHALL have port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-007 SHALL have port a  input  WIDTH  dividend; sampled with start.
REQ-008 SHALL have port b  input  WIDTH  divisor; sampled with start.
REQ-009 SHALL have port busy  output  1  high while a division is in progress (CALC or SIGN state).
REQ-010 SHALL have port done  output  1  high for exactly one cycle when z is valid (DONE state).
REQ-011 SHALL have port z  output  2*WIDTH  result {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}, registered.
REQ-012 SHALL have port div_by_zero  output  1  b was zero for the current result.
REQ-013 SHALL have port overflow  output  1  signed most-negative / -1 occurred for the current result.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, SIGN, DONE; reset state IDLE.
REQ-015 SHALL accept start only in IDLE; start in CALC, SIGN or DONE SHALL be ignored, with no effect on operands or result.
REQ-016 On an accepted start: latch signed_mode, the operand signs, and the magnitudes of a and b (absolute value when signed_mode=1, raw when 0), and clear the iteration counter.
REQ-017 Accepted start with b==0 SHALL go IDLE->DONE directly.
  - z = {a, all-ones}; div_by_zero=1; overflow=0.
  - done is visible after 1 edge.
REQ-018 Accepted start with b!=0 SHALL go IDLE->CALC.
REQ-019 CALC SHALL perform one restoring shift-subtract step per cycle, MSB first, for exactly WIDTH cycles.
  - Step: shift {rem,quo} left one bit; trial subtract the divisor magnitude.
  - Non-negative trial: keep the difference and set the quotient LSB to 1.
  - Negative trial: restore the remainder and set the quotient LSB to 0.
  - Datapath is WIDTH+1 bits wide, so the magnitude 2^(WIDTH-1) is handled.
REQ-020 After WIDTH steps, CALC->SIGN; SIGN->DONE after one cycle; DONE->IDLE after one cycle.
REQ-021 SIGN state behaviour:
  - signed_mode=1: negate the quotient if the operand signs differ; give the remainder the dividend's sign (truncating division).
  - signed_mode=0: pass the result unchanged.
REQ-022 Total latency from the accepting edge to done high SHALL be WIDTH+2 edges (b!=0).
REQ-023 Signed most-negative / -1 SHALL give quotient = most-negative (wrapped), remainder 0, overflow=1.
REQ-024 z, div_by_zero and overflow SHALL update only on entry to DONE and hold until the next DONE entry.
REQ-025 Invariant for non-error results: a == quotient*b + remainder (mod 2^WIDTH); |remainder| < |b|.
REQ-026 busy and done SHALL never be high together.

Reset
REQ-027 Reset (clear high) SHALL force asynchronously, at any time including mid-CALC:
  - state=IDLE;
  - z=0, busy=0, done=0, div_by_zero=0, overflow=0;
  - iteration counter and operand registers = 0;
  - mode register = SIGNED_DEFAULT.
REQ-028 First start after clear deasserts SHALL be accepted normally; no partial result from an aborted division SHALL appear.

Verification (WIDTH=32)
REQ-029 Signed 100/7 -> done after 34 edges, quotient=14, remainder=2, both flags 0.
REQ-030 Signed -100/7 -> quotient=-14 (0xFFFFFFF2), remainder=-2 (0xFFFFFFFE); signed 100/-7 -> quotient=-14, remainder=2.
REQ-031 Unsigned 0xFFFFFFFF/2 -> quotient=0x7FFFFFFF, remainder=1; the same operands signed -> quotient=0, remainder=-1.
REQ-032 b=0, a=0x1234 -> done after 1 edge, z={0x00001234,0xFFFFFFFF}, div_by_zero=1.
REQ-033 Signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0, overflow=1.
REQ-034 Control cases:
  - start pulsed in cycle 10 of CALC -> ignored; the original result arrives on time.
  - clear asserted in cycle 15 -> all outputs 0 immediately; a following 9/3 -> quotient=3, remainder=0.
